// File: rtl/ram_arbiter.sv
// ram_arbiter: hands the 16-word RAM to the CPU datapath or the front-panel loader.
// The loader is granted only at an instruction boundary or while halted, and the sequencer stalls throughout.
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mi,
    input  logic              cpu_ri,
    input  logic              cpu_ro,
    input  logic [DATA_W-1:0] cpu_bus_in,
    input  logic              cpu_boundary,
    input  logic              cpu_halted,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_lock,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [CNT_W-1:0]  ld_wr_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_LD_IDLE = 2'd1,
        ST_LD_WR   = 2'd2,
        ST_LD_RD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
    logic              ld_rvalid_q, ld_rvalid_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              ram_we_raw;

    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        ld_rdata_d  = ld_rdata_q;
        ld_rvalid_d = 1'b0;
        wr_count_d  = wr_count_q;
        ld_ready    = 1'b0;
        ram_addr    = mar_q;
        ram_we_raw  = 1'b0;
        ram_wdata   = cpu_bus_in;
        cpu_rdata   = '0;

        case (state_q)
            ST_CPU: begin
                // MI and RI together: the write below uses the old mar
                ram_we_raw = cpu_ri;
                cpu_rdata  = cpu_ro ? ram_rdata : '0;
                if (cpu_mi) begin
                    mar_d = cpu_bus_in[ADDR_W-1:0];
                end
                if (ld_lock && (cpu_boundary || cpu_halted)) begin
                    state_d = ST_LD_IDLE;
                end
            end
            ST_LD_IDLE: begin
                ld_ready = ld_lock;
                if (!ld_lock) begin
                    state_d = ST_CPU;
                end else if (ld_valid) begin
                    op_addr_d  = ld_addr;
                    op_wdata_d = ld_wdata;
                    state_d    = ld_we ? ST_LD_WR : ST_LD_RD;
                end
            end
            ST_LD_WR: begin
                ram_addr   = op_addr_q;
                ram_wdata  = op_wdata_q;
                ram_we_raw = 1'b1;
                if (wr_count_q != {CNT_W{1'b1}}) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
                state_d = ST_LD_IDLE;
            end
            ST_LD_RD: begin
                ram_addr    = op_addr_q;
                ld_rdata_d  = ram_rdata;
                ld_rvalid_d = 1'b1;
                state_d     = ST_LD_IDLE;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase

        cpu_stall_d = (state_d != ST_CPU);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CPU;
            mar_q       <= '0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            ld_rdata_q  <= '0;
            ld_rvalid_q <= 1'b0;
            cpu_stall_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            ld_rdata_q  <= ld_rdata_d;
            ld_rvalid_q <= ld_rvalid_d;
            cpu_stall_q <= cpu_stall_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Gate the strobe with reset so an interrupted write never reaches the RAM
    assign ram_we      = ram_we_raw & rst_n;
    assign cpu_stall   = cpu_stall_q;
    assign ld_rvalid   = ld_rvalid_q;
    assign ld_rdata    = ld_rdata_q;
    assign ld_wr_count = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized checks of ram_arbiter against a RAM-array/MAR reference model.
`default_nettype none

module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_mi, cpu_ri, cpu_ro;
    logic [7:0] cpu_bus_in;
    logic       cpu_boundary, cpu_halted;
    logic [7:0] cpu_rdata;
    logic       cpu_stall;
    logic       ld_lock, ld_valid, ld_ready, ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_rvalid;
    logic [7:0] ld_rdata;
    logic [7:0] ld_wr_count;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem     [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16] = '{default: 8'h00};
    logic [3:0] mar_m = 4'h0;
    int         wr_total = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_mi(cpu_mi), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro), .cpu_bus_in(cpu_bus_in),
        .cpu_boundary(cpu_boundary), .cpu_halted(cpu_halted),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_lock(ld_lock), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_wr_count(ld_wr_count),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] sat_count(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cpu_mi = 1'b0; cpu_ri = 1'b1; cpu_ro = 1'b0; cpu_bus_in = 8'h00;
        cpu_boundary = 1'b0; cpu_halted = 1'b0;
        ld_lock = 1'b1; ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'h0; ld_wdata = 8'h00;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ld_ready); end
        n_cmp++; if (ld_rvalid !== 1'b0 || ld_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rsp: got %b/%h want 0/00", ld_rvalid, ld_rdata); end
        n_cmp++; if (ld_wr_count !== 8'h00) begin n_err++; $display("FAIL reset_count: got %h want 00", ld_wr_count); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", ram_we); end
        n_cmp++; if (ram_addr !== 4'h0) begin n_err++; $display("FAIL reset_mar: got %h want 0", ram_addr); end
        @(negedge clk);
        rst_n = 1'b1; cpu_ri = 1'b0; ld_lock = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic test_cpu_path();
        logic mi, ri, ro, vld;
        logic [7:0] bus;
        for (int i = 0; i < 43; i++) begin
            if (i == 0)      begin mi = 1; ri = 0; ro = 0; bus = 8'h0E; vld = 0; end
            else if (i == 1) begin mi = 0; ri = 1; ro = 0; bus = 8'h2A; vld = 0; end
            else if (i == 2) begin mi = 0; ri = 0; ro = 1; bus = 8'h00; vld = 0; end
            else begin
                mi = 1'($urandom); ri = 1'($urandom); ro = 1'($urandom);
                bus = 8'($urandom); vld = 1'($urandom);
            end
            @(negedge clk);
            cpu_mi = mi; cpu_ri = ri; cpu_ro = ro; cpu_bus_in = bus; ld_valid = vld;
            #1;
            n_cmp++; if (cpu_rdata !== (ro ? ref_mem[mar_m] : 8'h00)) begin n_err++; $display("FAIL cpu_rdata[%0d]: got %h want %h", i, cpu_rdata, ro ? ref_mem[mar_m] : 8'h00); end
            n_cmp++; if (ram_addr !== mar_m || ram_we !== ri) begin n_err++; $display("FAIL cpu_ram[%0d]: got addr %h we %b want %h %b", i, ram_addr, ram_we, mar_m, ri); end
            n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL cpu_ready[%0d]: got %b want 0", i, ld_ready); end
            @(posedge clk);
            if (ri) ref_mem[mar_m] = bus;
            if (mi) mar_m = bus[3:0];
            #1;
            n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_stall[%0d]: got %b want 0", i, cpu_stall); end
            if (i == 1) begin
                n_cmp++; if (mem[14] !== 8'h2A) begin n_err++; $display("FAIL cpu_write14: got %h want 2a", mem[14]); end
            end
        end
        @(negedge clk);
        cpu_mi = 0; cpu_ri = 0; cpu_ro = 0; ld_valid = 0;
    endtask

    task automatic test_deferred_grant();
        @(negedge clk);
        ld_lock = 1'b1; cpu_boundary = 1'b0;
        for (int s = 2; s < 5; s++) begin
            if (s > 2) @(negedge clk);
            cpu_mi = (s == 2); cpu_ri = (s == 3); cpu_ro = (s == 4);
            cpu_bus_in = (s == 2) ? 8'h07 : 8'h99;
            #1;
            if (s == 4) begin
                n_cmp++; if (cpu_rdata !== 8'h99) begin n_err++; $display("FAIL defer_rdata: got %h want 99", cpu_rdata); end
            end
            @(posedge clk);
            if (s == 2) mar_m = 4'h7;
            if (s == 3) ref_mem[7] = 8'h99;
            #1;
            n_cmp++; if (cpu_stall !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL defer_early[%0d]: got stall %b ready %b want 0 0", s, cpu_stall, ld_ready); end
        end
        @(negedge clk);
        cpu_mi = 0; cpu_ri = 0; cpu_ro = 0; cpu_boundary = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cpu_stall !== 1'b1 || ld_ready !== 1'b1) begin n_err++; $display("FAIL defer_grant: got stall %b ready %b want 1 1", cpu_stall, ld_ready); end
        @(negedge clk);
        cpu_boundary = 1'b0;
    endtask

    // One loader op from LD_IDLE; CPU strobes are randomised to show they are ignored.
    task automatic loader_op(input logic we, input logic [3:0] a, input logic [7:0] d, input logic drop_lock);
        int k;
        @(negedge clk);
        ld_valid = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
        cpu_mi = 1'($urandom); cpu_ri = 1'($urandom); cpu_ro = 1'b1; cpu_bus_in = 8'($urandom);
        #1;
        k = 0;
        while (ld_ready !== 1'b1 && k < 8) begin @(negedge clk); #1; k++; end
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready_timeout: got %b want 1", ld_ready); ld_valid = 1'b0; return; end
        n_cmp++; if (ram_we !== 1'b0 || cpu_rdata !== 8'h00) begin n_err++; $display("FAIL ld_idle: got we %b rdata %h want 0 00", ram_we, cpu_rdata); end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        if (drop_lock) ld_lock = 1'b0;
        #1;
        n_cmp++; if (ld_ready !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL ld_busy: got ready %b stall %b want 0 1", ld_ready, cpu_stall); end
        n_cmp++; if (ram_we !== we || ram_addr !== a || cpu_rdata !== 8'h00) begin n_err++; $display("FAIL ld_ram: got we %b addr %h rdata %h want %b %h 00", ram_we, ram_addr, cpu_rdata, we, a); end
        if (we) begin
            n_cmp++; if (ram_wdata !== d) begin n_err++; $display("FAIL ld_wdata: got %h want %h", ram_wdata, d); end
        end
        @(posedge clk);
        if (we) begin ref_mem[a] = d; wr_total++; end
        #1;
        cpu_mi = 0; cpu_ri = 0; cpu_ro = 0;
        n_cmp++; if (ld_rvalid !== !we) begin n_err++; $display("FAIL ld_rvalid: got %b want %b", ld_rvalid, !we); end
        if (!we) begin
            n_cmp++; if (ld_rdata !== ref_mem[a]) begin n_err++; $display("FAIL ld_rdata[%h]: got %h want %h", a, ld_rdata, ref_mem[a]); end
        end
        n_cmp++; if (ld_wr_count !== sat_count(wr_total)) begin n_err++; $display("FAIL ld_count: got %0d want %0d", ld_wr_count, sat_count(wr_total)); end
    endtask

    task automatic test_loader_wr_rd();
        loader_op(1'b1, 4'h3, 8'h55, 1'b0);
        loader_op(1'b0, 4'h3, 8'h00, 1'b0);
        n_cmp++; if (ld_rdata !== 8'h55 || ld_wr_count !== 8'd1) begin n_err++; $display("FAIL ld_wr_rd: got %h cnt %0d want 55 1", ld_rdata, ld_wr_count); end
        @(posedge clk); #1;
        n_cmp++; if (ld_rvalid !== 1'b0 || ld_rdata !== 8'h55) begin n_err++; $display("FAIL ld_rsp_hold: got %b/%h want 0/55", ld_rvalid, ld_rdata); end
        n_cmp++; if (mem[14] !== ref_mem[14] || mem[7] !== 8'h99) begin n_err++; $display("FAIL ld_cpu_ignored: got %h %h want %h 99", mem[14], mem[7], ref_mem[14]); end
    endtask

    task automatic test_release_during_rd();
        loader_op(1'b0, 4'h3, 8'h00, 1'b1);
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rel_stall_hold: got %b want 1", cpu_stall); end
        @(posedge clk); #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rel_stall_clear: got %b want 0", cpu_stall); end
        n_cmp++; if (ram_addr !== mar_m) begin n_err++; $display("FAIL rel_mar: got %h want %h", ram_addr, mar_m); end
        @(negedge clk);
        cpu_ro = 1'b1; #1;
        n_cmp++; if (cpu_rdata !== ref_mem[mar_m]) begin n_err++; $display("FAIL rel_cpu_read: got %h want %h", cpu_rdata, ref_mem[mar_m]); end
        cpu_ro = 1'b0;
    endtask

    task automatic test_halted_grant();
        @(negedge clk);
        cpu_halted = 1'b1; cpu_boundary = 1'b0; ld_lock = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cpu_stall !== 1'b1 || ld_ready !== 1'b1) begin n_err++; $display("FAIL halt_grant: got stall %b ready %b want 1 1", cpu_stall, ld_ready); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) loader_op(1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) loader_op(1'b1, 4'($urandom), 8'($urandom), 1'b0);
        for (int a = 0; a < 16; a += 5) loader_op(1'b0, 4'(a), 8'h00, 1'b0);
        n_cmp++; if (ld_wr_count !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", ld_wr_count); end
    endtask

    task automatic test_reset_mid_wr();
        logic [7:0] d;
        d = ~ref_mem[9];
        @(negedge clk);
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'h9; ld_wdata = d;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0; #1;
        n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rstwr_pre: got %b want 1", ram_we); end
        rst_n = 1'b0; #1;
        n_cmp++; if (ram_we !== 1'b0 || cpu_stall !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL rstwr_async: got we %b stall %b ready %b want 0 0 0", ram_we, cpu_stall, ld_ready); end
        n_cmp++; if (ram_addr !== 4'h0 || ld_wr_count !== 8'h00) begin n_err++; $display("FAIL rstwr_state: got mar %h cnt %0d want 0 0", ram_addr, ld_wr_count); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ld_lock = 1'b0; cpu_halted = 1'b0;
        mar_m = 4'h0; wr_total = 0;
        #1;
        n_cmp++; if (mem[9] !== ref_mem[9]) begin n_err++; $display("FAIL rstwr_ram: got %h want %h", mem[9], ref_mem[9]); end
        cpu_mi = 1'b1; cpu_bus_in = 8'h09;
        @(posedge clk);
        @(negedge clk);
        cpu_mi = 1'b0; cpu_ro = 1'b1; #1;
        n_cmp++; if (cpu_rdata !== ref_mem[9]) begin n_err++; $display("FAIL rstwr_cpu_read: got %h want %h", cpu_rdata, ref_mem[9]); end
        cpu_ro = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_path();
        test_deferred_grant();
        test_loader_wr_rd();
        test_release_during_rd();
        test_halted_grant();
        test_saturation();
        test_reset_mid_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
